// File: rtl/uart_rx_mmio_pkg.sv
// uart_rx_pkg: shared types and constants for the memory-mapped UART receiver.
//   rx_state_t - receive FSM states
//   reg_sel_t  - register select on the bus port (DATA / STATUS)
//   ST_*       - bit positions inside the STATUS register
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    typedef enum logic {
        REG_DATA   = 1'b0,
        REG_STATUS = 1'b1
    } reg_sel_t;

    localparam int ST_AVAIL     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVR       = 2;
    localparam int ST_FERR      = 3;
    localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/uart_rx_mmio_if.sv
// uart_rx_mmio_if: one-request/one-ready register port used by the SoC IO decoder.
//   bus_req   - one-cycle access strobe (master -> slave)
//   bus_we    - 1 = write, 0 = read
//   bus_reg   - 0 = DATA, 1 = STATUS
//   bus_wdata - write data
//   bus_ready - one-cycle acknowledge, the edge after bus_req (slave -> master)
//   bus_rdata - read data, valid while bus_ready is high
interface uart_rx_mmio_if;

    logic        bus_req;
    logic        bus_we;
    logic        bus_reg;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_reg, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_reg, bus_wdata,
        output bus_ready, bus_rdata
    );

endinterface

// File: rtl/uart_rx_mmio_sync_fifo.sv
// sync_fifo: byte-wide synchronous FIFO with show-ahead output.
//   clk, resetn - clock, synchronous active-low reset
//   push, din   - write request and data; ignored when full unless a pop
//                 happens in the same cycle
//   pop         - remove the head; ignored when empty
//   dout        - current head (valid while !empty)
//   empty, full - occupancy flags
//   count       - occupancy, 0 .. 2**AW
module sync_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int            DEPTH     = 1 << AW;
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop frees the slot the simultaneous push lands in, so a full FIFO
    // still accepts a byte when it is being read in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign dout  = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are meaningful, and a resettable array costs a mux per bit.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped 8N1 UART receiver with an 8-byte-class FIFO.
//   clk, resetn - system clock, synchronous active-low reset
//   rx          - asynchronous serial input, idle high
//   bus         - register port (slave side of uart_rx_mmio_if)
//                   DATA   read : {23'b0, valid, byte}, pops the head if any
//                   DATA   write: acknowledged, no effect
//                   STATUS read : {16'b0, count, 4'b0, FERR, OVR, full, avail}
//                   STATUS write: wdata[2] clears OVR, wdata[3] clears FERR
//   rx_irq      - high while the FIFO holds at least one byte
module uart_rx_mmio
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_AW      = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx,
    uart_rx_mmio_if.slave     bus,
    output logic              rx_irq
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

    // ---------------------------------------------------------------
    // Input synchronizer; only rxs feeds decisions.
    // ---------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // ---------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             expired;
    logic             push;
    logic             ferr_set;

    assign expired = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxs) begin
                    state_d = DATA;
                    idx_d   = '0;
                    cnt_d   = BIT_LOAD;
                end else begin
                    // Line was high again at mid start bit: treat as a glitch.
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = BIT_LOAD;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 1'b1;
                end
            end
            STOP: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    // Missing stop bit: flag once and wait out the low line.
                    ferr_set = 1'b1;
                    state_d  = BREAK;
                end
            end
            BREAK: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------
    logic [7:0]     fifo_dout;
    logic           fifo_empty;
    logic           fifo_full;
    logic [FIFO_AW:0] fifo_count;
    logic           rd_pop;

    sync_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (rd_pop),
        .din    (shift_q),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    assign rx_irq = ~fifo_empty;

    // ---------------------------------------------------------------
    // Register port
    // ---------------------------------------------------------------
    logic        is_read;
    logic        is_write;
    logic        sel_status;
    logic        ovr_q;
    logic        ferr_q;
    logic        ovr_set;
    logic        ovr_clr;
    logic        ferr_clr;
    logic [7:0]  count8;
    logic [31:0] rd_word;
    logic        unused_wdata;

    assign is_read    = bus.bus_req & ~bus.bus_we;
    assign is_write   = bus.bus_req &  bus.bus_we;
    assign sel_status = (bus.bus_reg == REG_STATUS);

    assign rd_pop   = is_read & ~sel_status & ~fifo_empty;
    assign ovr_set  = push & fifo_full & ~rd_pop;
    assign ovr_clr  = is_write & sel_status & bus.bus_wdata[ST_OVR];
    assign ferr_clr = is_write & sel_status & bus.bus_wdata[ST_FERR];
    assign count8   = 8'(fifo_count);

    // Only the two clear bits of the write word are meaningful.
    assign unused_wdata = ^{bus.bus_wdata[31:4], bus.bus_wdata[1:0]};

    always_comb begin
        rd_word = '0;
        if (sel_status) begin
            rd_word[ST_AVAIL]              = ~fifo_empty;
            rd_word[ST_FULL]               = fifo_full;
            rd_word[ST_OVR]                = ovr_q;
            rd_word[ST_FERR]               = ferr_q;
            rd_word[ST_COUNT_LSB +: 8]     = count8;
        end else if (!fifo_empty) begin
            rd_word[8]   = 1'b1;
            rd_word[7:0] = fifo_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.bus_ready <= 1'b0;
            bus.bus_rdata <= '0;
            ovr_q         <= 1'b0;
            ferr_q        <= 1'b0;
        end else begin
            bus.bus_ready <= bus.bus_req;
            bus.bus_rdata <= is_read ? rd_word : '0;
            // Set has priority over a coincident write-1-to-clear.
            ovr_q         <= ovr_set  | (ovr_q  & ~ovr_clr);
            ferr_q        <= ferr_set | (ferr_q & ~ferr_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: directed self-checking bench for uart_rx_mmio
// (CLKS_PER_BIT = 8, FIFO_AW = 2). Inputs change and outputs are sampled on
// the falling clock edge.
module tb_uart_rx_mmio;

    localparam int CPB = 8;
    localparam int AW  = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic rx     = 1'b1;
    logic rx_irq;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_rx_mmio_if bus_if();

    uart_rx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .rx     (rx),
        .bus    (bus_if.slave),
        .rx_irq (rx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    // Called on a falling edge; returns on the falling edge that ends the
    // stop bit, leaving rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    // One register access plus an idle cycle. rdy is 1 only if bus_ready
    // was high the cycle after the request and low the cycle after that.
    task automatic bus_xfer(input logic we, input logic sel, input logic [31:0] wd,
                            output logic [31:0] rd, output logic rdy);
        logic first;
        bus_if.bus_req   = 1'b1;
        bus_if.bus_we    = we;
        bus_if.bus_reg   = sel;
        bus_if.bus_wdata = wd;
        @(negedge clk);
        bus_if.bus_req   = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_wdata = '0;
        first = bus_if.bus_ready;
        rd    = bus_if.bus_rdata;
        @(negedge clk);
        rdy = first & ~bus_if.bus_ready;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        r;
        n_cmp++; if (bus_if.bus_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus_if.bus_ready); end
        n_cmp++; if (bus_if.bus_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", bus_if.bus_rdata); end
        n_cmp++; if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", rx_irq); end
        bus_xfer(1'b0, 1'b1, 32'h0, d, r);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 00000000", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic        r;
        // Falling edge of rx is seen by the FSM 3 edges later, then 4 edges
        // of half bit, 64 of data and 8 of stop: stop sample on edge 79.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (78) @(negedge clk);
                n_cmp++; if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_early: got %b want 0", rx_irq); end
                @(negedge clk);
                n_cmp++; if (rx_irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq_rise: got %b want 1", rx_irq); end
            end
        join
        bus_xfer(1'b0, 1'b0, 32'h0, d, r);
        n_cmp++; if (d !== 32'h1A5) begin n_fail++; $display("FAIL basic_data: got %h want 000001a5", d); end
        n_cmp++; if (r !== 1'b1) begin n_fail++; $display("FAIL basic_ready_pulse: got %b want 1", r); end
        n_cmp++; if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_fall: got %b want 0", rx_irq); end
        bus_xfer(1'b0, 1'b0, 32'h0, d, r);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL basic_empty_read: got %h want 00000000", d); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic        r;
        for (int w = 1; w <= 3; w++) begin
            rx = 1'b0;
            repeat (w) @(negedge clk);
            rx = 1'b1;
            repeat (20) @(negedge clk);
            bus_xfer(1'b0, 1'b1, 32'h0, d, r);
            n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_%0d_status: got %h want 00000000", w, d); end
        end
        send_frame(8'h3C, 1'b1);
        bus_xfer(1'b0, 1'b0, 32'h0, d, r);
        n_cmp++; if (d !== 32'h13C) begin n_fail++; $display("FAIL glitch_next_frame: got %h want 0000013c", d); end
    endtask

    task automatic test_framing();
        logic [31:0] d;
        logic        r;
        send_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        bus_xfer(1'b0, 1'b1, 32'h0, d, r);
        n_cmp++; if (d !== 32'h8) begin n_fail++; $display("FAIL ferr_status: got %h want 00000008", d); end
        n_cmp++; if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL ferr_irq: got %b want 0", rx_irq); end
        bus_xfer(1'b1, 1'b1, 32'h8, d, r);
        n_cmp++; if (r !== 1'b1) begin n_fail++; $display("FAIL ferr_clear_ack: got %b want 1", r); end
        bus_xfer(1'b0, 1'b1, 32'h0, d, r);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL ferr_cleared: got %h want 00000000", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] exp;
        logic        r;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        bus_xfer(1'b0, 1'b1, 32'h0, d, r);
        n_cmp++; if (d !== 32'h0407) begin n_fail++; $display("FAIL b2b_status: got %h want 00000407", d); end
        // A DATA write is acknowledged and changes nothing.
        bus_xfer(1'b1, 1'b0, 32'hFFFF_FFFF, d, r);
        n_cmp++; if (r !== 1'b1) begin n_fail++; $display("FAIL b2b_data_write_ack: got %b want 1", r); end
        bus_xfer(1'b0, 1'b1, 32'h0, d, r);
        n_cmp++; if (d !== 32'h0407) begin n_fail++; $display("FAIL b2b_status_after_write: got %h want 00000407", d); end
        for (int i = 1; i <= 5; i++) begin
            exp = (i <= 4) ? (32'h100 | 32'(i)) : 32'h0;
            bus_xfer(1'b0, 1'b0, 32'h0, d, r);
            n_cmp++; if (d !== exp) begin n_fail++; $display("FAIL b2b_read_%0d: got %h want %h", i, d, exp); end
        end
        bus_xfer(1'b1, 1'b1, 32'h4, d, r);
        bus_xfer(1'b0, 1'b1, 32'h0, d, r);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL b2b_ovr_cleared: got %h want 00000000", d); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d;
        logic [31:0] pd;
        logic [31:0] exp;
        logic        r;
        logic        pr;
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
        // The read request is sampled on the same edge as the stop sample.
        fork
            send_frame(8'h15, 1'b1);
            begin
                repeat (78) @(negedge clk);
                bus_xfer(1'b0, 1'b0, 32'h0, pd, pr);
            end
        join
        n_cmp++; if (pd !== 32'h111) begin n_fail++; $display("FAIL ppf_pop_value: got %h want 00000111", pd); end
        bus_xfer(1'b0, 1'b1, 32'h0, d, r);
        n_cmp++; if (d !== 32'h0403) begin n_fail++; $display("FAIL ppf_status: got %h want 00000403", d); end
        for (int i = 0; i < 4; i++) begin
            exp = 32'h112 + 32'(i);
            bus_xfer(1'b0, 1'b0, 32'h0, d, r);
            n_cmp++; if (d !== exp) begin n_fail++; $display("FAIL ppf_drain_%0d: got %h want %h", i, d, exp); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic        r;
        // Bits 4..7 of 0xF0 are high, so the line stays idle after the reset.
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (43) @(negedge clk);
                resetn = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        bus_xfer(1'b0, 1'b1, 32'h0, d, r);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_status: got %h want 00000000", d); end
        n_cmp++; if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_irq: got %b want 0", rx_irq); end
        send_frame(8'h7E, 1'b1);
        bus_xfer(1'b0, 1'b0, 32'h0, d, r);
        n_cmp++; if (d !== 32'h17E) begin n_fail++; $display("FAIL rst_mid_next_frame: got %h want 0000017e", d); end
    endtask

    initial begin
        bus_if.bus_req   = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_reg   = 1'b0;
        bus_if.bus_wdata = '0;
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_push_pop_full();
        test_reset_mid_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
Memory-mapped 8N1 UART receiver, the inbound counterpart of the existing UART transmitter. It samples the asynchronous `rx` pin at mid-bit, assembles bytes LSB-first and buffers them in a small synchronous FIFO. The CPU reads through a one-request/one-ready register port, the same strobe style the SoC memory/IO decoder already uses for TX. It sits beside the TX UART in the SoC top, on the IO region next to the TX address.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200); legal range 4..65535.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8 bytes.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- rx  in  1  asynchronous serial input, idle high
- bus_req  in  1  one-cycle access strobe
- bus_we  in  1  1 = write, 0 = read (qualified by bus_req)
- bus_reg  in  1  0 = DATA register, 1 = STATUS register
- bus_wdata  in  32  write data
- bus_ready  out  1  one-cycle acknowledge
- bus_rdata  out  32  read data, valid while bus_ready = 1
- rx_irq  out  1  high while FIFO is non-empty

Behaviour:
- Reset values: bus_ready = 0, bus_rdata = 0, rx_irq = 0. Synchronizer flops = 1, FSM in IDLE, FIFO empty, sticky flags cleared. Reset mid-frame discards the partial byte.
- Input: 2-flop synchronizer on `rx`; all FSM decisions use the second flop (rxs).
- Bit counter: width clog2(CLKS_PER_BIT); it is loaded on each state entry and an expiry is counter == 0.
- Receive FSM states and transitions:
  - IDLE: rxs == 0 → START; load counter with CLKS_PER_BIT/2 - 1.
  - START: on expiry, rxs == 0 → DATA (bit index 0, counter CLKS_PER_BIT - 1); rxs == 1 → IDLE (glitch, no error).
  - DATA: on expiry, shift[idx] <= rxs and reload counter; after idx == 7 → STOP.
  - STOP: on expiry, rxs == 1 → push byte, then IDLE. rxs == 0 → set FERR, discard byte, go to BREAK.
  - BREAK: wait for rxs == 1, then IDLE. A held-low line therefore yields exactly one FERR and no bytes.
- Push when FIFO is full and no pop occurs in the same cycle: byte dropped, OVR set, FIFO contents untouched.
- Push and pop in the same cycle are both performed; the count is unchanged, and this applies even when the FIFO is full (no OVR).
- Latency: the byte becomes visible (rx_irq = 1, STATUS.avail = 1) the cycle after the stop-bit sample.
- Bus protocol:
  - bus_req is sampled at a rising edge; bus_ready pulses for exactly one cycle on the next edge, and bus_rdata is registered alongside it.
  - Any request is always acknowledged; there are no wait states.
  - bus_req is never asserted while bus_ready is high.
- DATA read: rdata = {23'b0, valid, byte}.
  - Non-empty: valid = 1, byte = FIFO head, head popped.
  - Empty: rdata = 0 and nothing is popped.
- DATA write: ignored, but still acknowledged.
- STATUS read: rdata = {16'b0, count[7:0], 4'b0, FERR, OVR, full, avail}. count is zero-extended occupancy, 0..2**FIFO_AW.
- STATUS write: write-1-to-clear. wdata[2] clears OVR and wdata[3] clears FERR. If a clear coincides with a new set event, set wins.
- Pointer wrap: read/write pointers are FIFO_AW bits wide with natural wrap; occupancy is a FIFO_AW+1-bit counter.

Decomposition:
- Package uart_rx_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK};
  - register selects REG_DATA = 0, REG_STATUS = 1;
  - STATUS bit indices ST_AVAIL = 0, ST_FULL = 1, ST_OVR = 2, ST_FERR = 3, ST_COUNT_LSB = 8.
- One sub-module, sync_fifo (parameter AW, width 8; ports push, pop, din, dout, empty, full, count). dout is the show-ahead head.
- FSM, synchronizer and register logic stay in uart_rx_mmio.

Test Plan (CLKS_PER_BIT = 8, FIFO_AW = 2):
- Send 0xA5 as an 8N1 frame; then read DATA → rdata = 0x1A5. rx_irq rises 1 cycle after the stop sample and falls after the read. A second DATA read → 0x000.
- 1-cycle... 3-cycle low glitch on rx in IDLE → no byte, no FERR, FSM returns to IDLE; a following 0x3C frame is received correctly.
- Stop bit driven 0 in a 0x55 frame, line held low for 40 cycles → STATUS = 0x8 (FERR only), FIFO empty. Write STATUS 0x8 → STATUS reads 0x0.
- Five back-to-back frames 0x01..0x05 with no reads:
  - STATUS → 0x0407 (count 4, OVR, full, avail);
  - DATA reads return 0x101, 0x102, 0x103, 0x104, then 0x000.
- Frame whose stop sample coincides with a DATA pop while the FIFO is full → byte accepted, OVR stays 0, count stays 4.
- Assert resetn = 0 for 1 cycle during bit 4 of a frame → STATUS = 0, no byte pushed. The next full frame 0x7E is received intact.
